time_set_ctrl: RTL and testbench

- Controller that lets the user set the wall-clock time held by the timer block, using the two board push-buttons.
- Debounces button[0] (MODE) and button[1] (INC) and walks a RUN -> SET_HOUR -> SET_MIN FSM.
- Edits a private BCD copy of the time and issues a one-cycle load strobe to the timer on commit.
- Drives blink enables that the display block uses to flash the field being edited.

---
 rtl/time_set_ctrl_pkg.sv | 57 +++++
 rtl/time_set_ctrl_btn_debounce.sv | 52 +++++
 rtl/time_set_ctrl.sv | 154 +++++++++++++++
 tb/tb_time_set_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_ctrl_pkg.sv
// Shared types, BCD limits and increment helpers for the time-setting controller.
// Button indices select bits of the raw button bus.
package time_set_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_SET_HOUR = 2'd1,
      ST_SET_MIN  = 2'd2
   } state_e;

   localparam int BTN_MODE = 0;
   localparam int BTN_INC  = 1;

   localparam logic [1:0] HOUR_MAX_T = 2'd2;
   localparam logic [3:0] HOUR_MAX_U = 4'd3;
   localparam logic [2:0] MIN_MAX_T  = 3'd5;
   localparam logic [3:0] BCD_MAX    = 4'd9;

   typedef struct packed {
      logic [1:0] h1;
      logic [3:0] h0;
   } hour_t;

   typedef struct packed {
      logic [2:0] m1;
      logic [3:0] m0;
   } min_t;

   // 24 h wrap; an out-of-range tens digit of 3 also wraps to 00.
   function automatic hour_t bcd_hour_inc(input hour_t h);
      hour_t r;
      r = h;
      if ((h.h1 == HOUR_MAX_T && h.h0 >= HOUR_MAX_U) || h.h1 == 2'd3) begin
         r = '0;
      end else if (h.h0 >= BCD_MAX) begin
         r.h0 = 4'd0;
         r.h1 = h.h1 + 2'd1;
      end else begin
         r.h0 = h.h0 + 4'd1;
      end
      return r;
   endfunction

   // Minutes roll over 59 -> 00 without carrying into the hour field.
   function automatic min_t bcd_min_inc(input min_t m);
      min_t r;
      r = m;
      if (m.m0 >= BCD_MAX) begin
         r.m0 = 4'd0;
         r.m1 = (m.m1 >= MIN_MAX_T) ? 3'd0 : m.m1 + 3'd1;
      end else begin
         r.m0 = m.m0 + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Two-flop synchronizer plus stability counter for one push-button.
// press_o pulses for one cycle on each accepted 0->1 transition.
module btn_debounce #(
   parameter int CNT_W           = 32,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic level_o,
   output logic press_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d   = cnt_q + CNT_W'(1);
      level_d = level_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         level_d = sync2_q;
         cnt_d   = '0;
      end
      press_d = level_d & ~level_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
   assign press_o = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Push-button time-setting controller: RUN -> SET_HOUR -> SET_MIN with INC
// auto-repeat, idle timeout, blink enables and a one-cycle load strobe.
module time_set_ctrl
   import time_set_ctrl_pkg::*;
#(
   parameter int CNT_W           = 32,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int HOLD_CYCLES     = 25000000,
   parameter int REPEAT_CYCLES   = 10000000,
   parameter int TIMEOUT_CYCLES  = 500000000,
   parameter int BLINK_CYCLES    = 12500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] button,
   input  logic [1:0] cur_hour1,
   input  logic [3:0] cur_hour0,
   input  logic [2:0] cur_min1,
   input  logic [3:0] cur_min0,
   output logic [1:0] set_hour1,
   output logic [3:0] set_hour0,
   output logic [2:0] set_min1,
   output logic [3:0] set_min0,
   output logic       set_load,
   output logic       editing,
   output logic       blink_hour,
   output logic       blink_min
);

   localparam logic [CNT_W-1:0] HOLD_AT    = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_RELD  = CNT_W'(HOLD_CYCLES - REPEAT_CYCLES + 1);
   localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYCLES - 1);

   logic unused_mode_lvl;
   logic mode_press, inc_press, inc_lvl;
   logic rep_evt, mode_evt, inc_evt, any_evt;

   state_e           state_q, state_d;
   hour_t            hour_q, hour_d;
   min_t             min_q, min_d;
   logic             load_q, load_d;
   logic             phase_q, phase_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0] idle_q, idle_d;
   logic [CNT_W-1:0] blink_q, blink_d;

   btn_debounce #(.CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (button[BTN_MODE]),
      .level_o (unused_mode_lvl),
      .press_o (mode_press)
   );

   btn_debounce #(.CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (button[BTN_INC]),
      .level_o (inc_lvl),
      .press_o (inc_press)
   );

   // Hold counter reloads so that successive repeats land REPEAT_CYCLES apart.
   assign rep_evt  = inc_lvl && (hold_q == HOLD_AT);
   assign mode_evt = mode_press;
   assign inc_evt  = (inc_press | rep_evt) & ~mode_press;
   assign any_evt  = mode_evt | inc_evt;

   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_RUN;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:      if (mode_evt) state_d = ST_SET_HOUR;
         ST_SET_HOUR: if (mode_evt) state_d = ST_SET_MIN;
                      else if (!inc_evt && idle_q == IDLE_LAST) state_d = ST_RUN;
         ST_SET_MIN:  if (mode_evt) state_d = ST_RUN;
                      else if (!inc_evt && idle_q == IDLE_LAST) state_d = ST_RUN;
         default:     state_d = ST_RUN;
      endcase
   end

   always_comb begin
      editing    = (state_q != ST_RUN);
      blink_hour = phase_q & (state_q == ST_SET_HOUR);
      blink_min  = phase_q & (state_q == ST_SET_MIN);
   end

   always_comb begin
      hour_d = hour_q;
      min_d  = min_q;
      load_d = 1'b0;
      case (state_q)
         ST_RUN: if (mode_evt) begin
            hour_d.h1 = cur_hour1;
            hour_d.h0 = cur_hour0;
            min_d.m1  = cur_min1;
            min_d.m0  = cur_min0;
         end
         ST_SET_HOUR: if (inc_evt) hour_d = bcd_hour_inc(hour_q);
         ST_SET_MIN:  if (mode_evt) load_d = 1'b1;
                      else if (inc_evt) min_d = bcd_min_inc(min_q);
         default: ;
      endcase

      if (!inc_lvl)     hold_d = '0;
      else if (rep_evt) hold_d = HOLD_RELD;
      else              hold_d = hold_q + CNT_W'(1);

      idle_d = (state_d == ST_RUN || any_evt) ? '0 : idle_q + CNT_W'(1);

      // Restarting the blink on entry keeps the first half-period lit.
      phase_d = phase_q;
      blink_d = blink_q + CNT_W'(1);
      if (state_q == ST_RUN && state_d == ST_SET_HOUR) begin
         phase_d = 1'b0;
         blink_d = '0;
      end else if (blink_q == BLINK_LAST) begin
         phase_d = ~phase_q;
         blink_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hour_q  <= '0;
         min_q   <= '0;
         load_q  <= 1'b0;
         phase_q <= 1'b0;
         hold_q  <= '0;
         idle_q  <= '0;
         blink_q <= '0;
      end else begin
         hour_q  <= hour_d;
         min_q   <= min_d;
         load_q  <= load_d;
         phase_q <= phase_d;
         hold_q  <= hold_d;
         idle_q  <= idle_d;
         blink_q <= blink_d;
      end
   end

   assign set_hour1 = hour_q.h1;
   assign set_hour0 = hour_q.h0;
   assign set_min1  = min_q.m1;
   assign set_min0  = min_q.m0;
   assign set_load  = load_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short debounce/hold/repeat/timeout/blink times.
module tb_time_set_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] button;
   logic [1:0] cur_hour1;
   logic [3:0] cur_hour0;
   logic [2:0] cur_min1;
   logic [3:0] cur_min0;
   logic [1:0] set_hour1;
   logic [3:0] set_hour0;
   logic [2:0] set_min1;
   logic [3:0] set_min0;
   logic       set_load, editing, blink_hour, blink_min;

   int checks = 0;
   int errors = 0;
   int load_cnt = 0;
   logic [5:0] ld_hour = 6'h3f;
   logic [6:0] ld_min  = 7'h7f;

   time_set_ctrl #(
      .CNT_W(32), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20),
      .REPEAT_CYCLES(8), .TIMEOUT_CYCLES(100), .BLINK_CYCLES(10)
   ) dut (
      .clk(clk), .rst(rst), .button(button),
      .cur_hour1(cur_hour1), .cur_hour0(cur_hour0),
      .cur_min1(cur_min1), .cur_min0(cur_min0),
      .set_hour1(set_hour1), .set_hour0(set_hour0),
      .set_min1(set_min1), .set_min0(set_min0),
      .set_load(set_load), .editing(editing),
      .blink_hour(blink_hour), .blink_min(blink_min)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (set_load === 1'b1) begin
         load_cnt = load_cnt + 1;
         ld_hour  = {set_hour1, set_hour0};
         ld_min   = {set_min1, set_min0};
      end
   end

   wire [5:0]  hour_w = {set_hour1, set_hour0};
   wire [6:0]  min_w  = {set_min1, set_min0};
   wire [16:0] outs_w = {set_hour1, set_hour0, set_min1, set_min0,
                         set_load, editing, blink_hour, blink_min};

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int idx);
      button[idx] = 1'b1;
      step(8);
      button[idx] = 1'b0;
      step(10);
   endtask

   task automatic set_cur(input logic [5:0] h, input logic [6:0] m);
      cur_hour1 = h[5:4];
      cur_hour0 = h[3:0];
      cur_min1  = m[6:4];
      cur_min0  = m[3:0];
   endtask

   task automatic do_reset();
      rst = 1'b0;
      button = 2'b00;
      step(3);
      rst = 1'b1;
      step(1);
   endtask

   task automatic test_reset();
      int ed_hi;
      set_cur(6'h13, 7'h47);
      rst = 1'b0;
      button = 2'b00;
      step(3);
      checks++;
      if (outs_w !== 17'd0) begin
         $display("FAIL reset_outputs got %h want 0", outs_w); errors++;
      end
      rst = 1'b1;
      button = 2'b11; step(1);
      button = 2'b00; step(1);
      button = 2'b11; step(1);
      button = 2'b00;
      ed_hi = 0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         if (editing !== 1'b0) ed_hi++;
      end
      checks++;
      if (ed_hi != 0) begin
         $display("FAIL bounce_editing got %0d high cycles want 0", ed_hi); errors++;
      end
      checks++;
      if (outs_w !== 17'd0 || load_cnt != 0) begin
         $display("FAIL bounce_outputs got %h loads %0d want 0 0", outs_w, load_cnt); errors++;
      end
   endtask

   task automatic test_edit_sequence();
      int base;
      base = load_cnt;
      set_cur(6'h13, 7'h47);
      button[0] = 1'b1;
      step(6);
      checks++;
      if (editing !== 1'b0) begin
         $display("FAIL edit_early got %b want 0", editing); errors++;
      end
      step(1);
      checks++;
      if (editing !== 1'b1) begin
         $display("FAIL edit_rise got %b want 1", editing); errors++;
      end
      checks++;
      if (hour_w !== 6'h13 || min_w !== 7'h47) begin
         $display("FAIL capture got %h:%h want 13:47", hour_w, min_w); errors++;
      end
      step(1);
      button[0] = 1'b0;
      step(10);
      press(1); press(1);
      checks++;
      if (hour_w !== 6'h15) begin
         $display("FAIL hour_inc got %h want 15", hour_w); errors++;
      end
      press(0);
      press(1); press(1); press(1);
      checks++;
      if (min_w !== 7'h50 || editing !== 1'b1) begin
         $display("FAIL min_inc got %h ed %b want 50 1", min_w, editing); errors++;
      end
      press(0);
      checks++;
      if (load_cnt - base != 1 || ld_hour !== 6'h15 || ld_min !== 7'h50) begin
         $display("FAIL commit got loads %0d set %h:%h want 1 15:50", load_cnt - base, ld_hour, ld_min);
         errors++;
      end
      checks++;
      if (editing !== 1'b0) begin
         $display("FAIL back_to_run got %b want 0", editing); errors++;
      end
   endtask

   task automatic test_wrap();
      int base;
      base = load_cnt;
      set_cur(6'h23, 7'h59);
      press(0); press(1);
      checks++;
      if (hour_w !== 6'h00) begin
         $display("FAIL hour_wrap got %h want 00", hour_w); errors++;
      end
      press(0); press(1);
      checks++;
      if (min_w !== 7'h00 || hour_w !== 6'h00) begin
         $display("FAIL min_wrap got %h:%h want 00:00", hour_w, min_w); errors++;
      end
      press(0);
      checks++;
      if (load_cnt - base != 1 || ld_hour !== 6'h00 || ld_min !== 7'h00) begin
         $display("FAIL wrap_commit got loads %0d set %h:%h want 1 00:00", load_cnt - base, ld_hour, ld_min);
         errors++;
      end
   endtask

   task automatic test_auto_repeat();
      logic [5:0] exp_h [6];
      int gaps [6];
      exp_h = '{6'h10, 6'h10, 6'h11, 6'h12, 6'h13, 6'h14};
      gaps  = '{7, 19, 1, 8, 8, 8};
      do_reset();
      set_cur(6'h09, 7'h00);
      press(0);
      checks++;
      if (hour_w !== 6'h09) begin
         $display("FAIL repeat_start got %h want 09", hour_w); errors++;
      end
      button[1] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(gaps[i]);
         checks++;
         if (hour_w !== exp_h[i]) begin
            $display("FAIL repeat_%0d got %h want %h", i, hour_w, exp_h[i]); errors++;
         end
      end
      step(8);
      checks++;
      if (hour_w !== 6'h15) begin
         $display("FAIL repeat_last got %h want 15", hour_w); errors++;
      end
      step(1);
      button[1] = 1'b0;
      step(20);
      checks++;
      if (hour_w !== 6'h15 || editing !== 1'b1) begin
         $display("FAIL repeat_release got %h ed %b want 15 1", hour_w, editing); errors++;
      end
   endtask

   task automatic test_timeout_simul();
      int base;
      do_reset();
      base = load_cnt;
      set_cur(6'h10, 7'h20);
      press(0);
      button[0] = 1'b1;
      step(8);
      button[0] = 1'b0;
      step(10);
      checks++;
      if (editing !== 1'b1 || blink_hour !== 1'b0) begin
         $display("FAIL set_min_entry got ed %b bh %b want 1 0", editing, blink_hour); errors++;
      end
      step(88);
      checks++;
      if (editing !== 1'b1) begin
         $display("FAIL timeout_early got %b want 1", editing); errors++;
      end
      step(1);
      checks++;
      if (editing !== 1'b0 || load_cnt != base) begin
         $display("FAIL timeout got ed %b loads %0d want 0 0", editing, load_cnt - base); errors++;
      end
      set_cur(6'h12, 7'h34);
      button = 2'b11;
      step(8);
      button = 2'b00;
      step(10);
      checks++;
      if (editing !== 1'b1 || hour_w !== 6'h12 || min_w !== 7'h34) begin
         $display("FAIL simultaneous got ed %b %h:%h want 1 12:34", editing, hour_w, min_w); errors++;
      end
   endtask

   task automatic test_reset_mid_edit();
      int base;
      do_reset();
      base = load_cnt;
      set_cur(6'h08, 7'h15);
      button[0] = 1'b1;
      step(7);
      checks++;
      if (editing !== 1'b1 || blink_hour !== 1'b0) begin
         $display("FAIL blink_entry got ed %b bh %b want 1 0", editing, blink_hour); errors++;
      end
      step(1);
      button[0] = 1'b0;
      step(8);
      checks++;
      if (blink_hour !== 1'b0) begin
         $display("FAIL blink_lit got %b want 0", blink_hour); errors++;
      end
      step(1);
      checks++;
      if (blink_hour !== 1'b1 || blink_min !== 1'b0) begin
         $display("FAIL blink_on got bh %b bm %b want 1 0", blink_hour, blink_min); errors++;
      end
      step(9);
      checks++;
      if (blink_hour !== 1'b1) begin
         $display("FAIL blink_hold got %b want 1", blink_hour); errors++;
      end
      step(1);
      checks++;
      if (blink_hour !== 1'b0) begin
         $display("FAIL blink_off got %b want 0", blink_hour); errors++;
      end
      step(10);
      checks++;
      if (blink_hour !== 1'b1) begin
         $display("FAIL blink_on2 got %b want 1", blink_hour); errors++;
      end
      rst = 1'b0;
      step(1);
      checks++;
      if (outs_w !== 17'd0) begin
         $display("FAIL mid_reset got %h want 0", outs_w); errors++;
      end
      rst = 1'b1;
      step(5);
      checks++;
      if (outs_w !== 17'd0 || load_cnt != base) begin
         $display("FAIL after_reset got %h loads %0d want 0 0", outs_w, load_cnt - base); errors++;
      end
   endtask

   initial begin
      rst = 1'b0;
      button = 2'b00;
      set_cur(6'h00, 7'h00);
      test_reset();
      test_edit_sequence();
      test_wrap();
      test_auto_repeat();
      test_timeout_simul();
      test_reset_mid_edit();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
